nanorv32_timer: RTL and testbench

APB-programmable 32-bit up-counting timer with 16-bit prescaler, compare match, one-shot/auto-reload modes and a level interrupt. It sits directly upstream of the interrupt controller: `timer_irq` drives one of its `irqs[7:0]` inputs. It shares the controller's APB slave conventions: writes take effect in the setup phase, reads are combinational, the slave is always ready and never errors.

---
 rtl/nanorv32_timer_if.sv | 34 +++
 rtl/nanorv32_timer.sv | 124 ++++++++++++
 tb/tb_nanorv32_timer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_timer_if.sv
// APB slave bundle between the bus fabric and nanorv32_timer.
// master drives select/address/strobes/wdata; slave returns prdata/pready/pslverr.
interface nanorv32_timer_if;
    logic        apb_timer_psel;
    logic [11:0] apb_timer_paddr;
    logic        apb_timer_penable;
    logic        apb_timer_pwrite;
    logic [31:0] apb_timer_pwdata;
    logic [31:0] timer_apb_prdata;
    logic        timer_apb_pready;
    logic        timer_apb_pslverr;

    modport master (
        output apb_timer_psel,
        output apb_timer_paddr,
        output apb_timer_penable,
        output apb_timer_pwrite,
        output apb_timer_pwdata,
        input  timer_apb_prdata,
        input  timer_apb_pready,
        input  timer_apb_pslverr
    );

    modport slave (
        input  apb_timer_psel,
        input  apb_timer_paddr,
        input  apb_timer_penable,
        input  apb_timer_pwrite,
        input  apb_timer_pwdata,
        output timer_apb_prdata,
        output timer_apb_pready,
        output timer_apb_pslverr
    );
endinterface

// File: rtl/nanorv32_timer.sv
// 32-bit prescaled up-counter with compare match, one-shot/auto-reload, level irq.
// Ports: clk, rst (sync, high), apb (APB slave bundle), timer_irq (MATCH & IE).
module nanorv32_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    nanorv32_timer_if.slave  apb,
    output logic             timer_irq
);

    logic                  en;
    logic                  reload;
    logic                  ie;
    logic                  match;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [31:0]           count;
    logic [31:0]           compare;

    logic [2:0]  sel;
    logic [31:0] wdata;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_pre;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic        tick;
    logic        step;
    logic        hit;
    logic        match_evt;
    logic        en_next;
    logic        unused;

    assign sel   = apb.apb_timer_paddr[4:2];
    assign wdata = apb.apb_timer_pwdata;
    assign wr    = apb.apb_timer_psel & ~apb.apb_timer_penable
                 & apb.apb_timer_pwrite;

    assign wr_ctrl   = wr & (sel == 3'd0);
    assign wr_pre    = wr & (sel == 3'd1);
    assign wr_count  = wr & (sel == 3'd2);
    assign wr_cmp    = wr & (sel == 3'd3);
    assign wr_status = wr & (sel == 3'd4);

    assign tick = en & (pcnt == prescale);
    // A COUNT write, or a CTRL write that disables, swallows this tick.
    assign step = tick & ~wr_count & ~(wr_ctrl & ~wdata[0]);
    assign hit  = (count == compare);
    assign match_evt = step & hit;

    always_comb begin
        en_next = en;
        if (wr_ctrl)
            en_next = wdata[0];
        else if (match_evt & ~reload)
            en_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            ie       <= 1'b0;
            match    <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= 32'd0;
            compare  <= 32'hFFFF_FFFF;
        end else begin
            en <= en_next;
            if (wr_ctrl) begin
                reload <= wdata[1];
                ie     <= wdata[2];
            end

            // Start every enabled run from a fresh prescale phase.
            if (!en || !en_next)
                pcnt <= '0;
            else if (tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESCALE_W'(1);

            if (wr_pre)
                prescale <= wdata[PRESCALE_W-1:0];
            if (wr_cmp)
                compare <= wdata;

            if (wr_count)
                count <= wdata;
            else if (step)
                count <= hit ? 32'd0 : count + 32'd1;

            // A new match beats a simultaneous W1C.
            if (match_evt)
                match <= 1'b1;
            else if (wr_status & wdata[0])
                match <= 1'b0;
        end
    end

    always_comb begin
        apb.timer_apb_prdata = 32'd0;
        if (apb.apb_timer_psel & ~apb.apb_timer_pwrite) begin
            case (sel)
                3'd0: apb.timer_apb_prdata = {29'd0, ie, reload, en};
                3'd1: apb.timer_apb_prdata = 32'(prescale);
                3'd2: apb.timer_apb_prdata = count;
                3'd3: apb.timer_apb_prdata = compare;
                3'd4: apb.timer_apb_prdata = {31'd0, match};
                default: apb.timer_apb_prdata = 32'd0;
            endcase
        end
    end

    assign apb.timer_apb_pready  = 1'b1;
    assign apb.timer_apb_pslverr = 1'b0;
    assign timer_irq = match & ie;

    assign unused = ^{apb.apb_timer_paddr[11:5], apb.apb_timer_paddr[1:0]};

endmodule

// File: tb/tb_nanorv32_timer.sv
// Directed bench for nanorv32_timer: reset, modes, wrap, collisions, irq gating.
// Expected values are hand-derived cycle counts and register contents.
module tb_nanorv32_timer;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_PRE  = 12'h004;
    localparam logic [11:0] A_CNT  = 12'h008;
    localparam logic [11:0] A_CMP  = 12'h00C;
    localparam logic [11:0] A_STAT = 12'h010;

    logic clk;
    logic rst;
    logic timer_irq;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    nanorv32_timer_if bus ();

    nanorv32_timer #(.PRESCALE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .apb       (bus),
        .timer_irq (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Setup phase now, write edge next, then one access cycle.
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d,
                          output int wedge);
        bus.apb_timer_psel    = 1'b1;
        bus.apb_timer_penable = 1'b0;
        bus.apb_timer_pwrite  = 1'b1;
        bus.apb_timer_paddr   = a;
        bus.apb_timer_pwdata  = d;
        @(posedge clk);
        #1;
        wedge = cyc;
        bus.apb_timer_penable = 1'b1;
        @(posedge clk);
        #1;
        bus.apb_timer_psel    = 1'b0;
        bus.apb_timer_penable = 1'b0;
        bus.apb_timer_pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        int e;
        apb_wr(a, d, e);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.apb_timer_psel    = 1'b1;
        bus.apb_timer_penable = 1'b0;
        bus.apb_timer_pwrite  = 1'b0;
        bus.apb_timer_paddr   = a;
        #1;
        d = bus.timer_apb_prdata;
        bus.apb_timer_psel    = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_irq(input int budget, output int at);
        at = -1000;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (timer_irq) begin
                at = cyc;
                break;
            end
        end
    endtask

    logic [31:0] d;
    int          we;
    int          at;
    int          at2;
    int          hits;

    initial begin
        bus.apb_timer_psel    = 1'b0;
        bus.apb_timer_penable = 1'b0;
        bus.apb_timer_pwrite  = 1'b0;
        bus.apb_timer_paddr   = 12'h0;
        bus.apb_timer_pwdata  = 32'h0;
        rst = 1'b1;
        step_n(2);
        rst = 1'b0;

        check("rst_prdata_idle", bus.timer_apb_prdata, 32'h0);
        rd(A_CTRL, d); check("rst_ctrl", d, 32'h0);
        rd(A_PRE, d);  check("rst_pre", d, 32'h0);
        rd(A_CNT, d);  check("rst_count", d, 32'h0);
        rd(A_CMP, d);  check("rst_cmp", d, 32'hFFFF_FFFF);
        rd(A_STAT, d); check("rst_status", d, 32'h0);
        check("rst_irq", {31'd0, timer_irq}, 32'h0);
        check("pready", {31'd0, bus.timer_apb_pready}, 32'h1);
        check("pslverr", {31'd0, bus.timer_apb_pslverr}, 32'h0);

        // Auto-reload, C=4, P=0: irq 5 cycles after enable, period 5.
        wr(A_PRE, 32'h0);
        wr(A_CMP, 32'h4);
        apb_wr(A_CTRL, 32'h7, we);
        wait_irq(20, at);
        check("ar_latency", 32'(at - we), 32'd5);
        wr(A_STAT, 32'h1);
        check("ar_w1c_irq", {31'd0, timer_irq}, 32'h0);
        wait_irq(20, at2);
        check("ar_period", 32'(at2 - at), 32'd5);

        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'h0);

        // One-shot with prescale 3, compare 2: match at 12 cycles.
        wr(A_PRE, 32'h3);
        wr(A_CMP, 32'h2);
        apb_wr(A_CTRL, 32'h5, we);
        wait_irq(40, at);
        check("os_latency", 32'(at - we), 32'd12);
        rd(A_CTRL, d); check("os_ctrl", d, 32'h4);
        rd(A_CNT, d);  check("os_count", d, 32'h0);
        wr(A_STAT, 32'h1);
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            step_n(1);
            if (timer_irq) hits++;
        end
        check("os_no_rematch", 32'(hits), 32'd0);
        rd(A_STAT, d); check("os_status", d, 32'h0);

        // Wrap through 0xFFFFFFFF: match 8 cycles after enable.
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'h0);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h5);
        apb_wr(A_CTRL, 32'h1, we);
        rd(A_CNT, d); check("wrap_ffff", d, 32'hFFFF_FFFF);
        step_n(1);
        rd(A_CNT, d); check("wrap_zero", d, 32'h0);
        at = -1000;
        for (int i = 0; i < 20; i++) begin
            step_n(1);
            rd(A_STAT, d);
            if (d[0]) begin
                at = cyc;
                break;
            end
        end
        check("wrap_latency", 32'(at - we), 32'd8);
        check("wrap_irq_gated", {31'd0, timer_irq}, 32'h0);
        rd(A_CTRL, d); check("wrap_ctrl", d, 32'h0);

        // IE gating: pending match surfaces once IE is set.
        wr(A_CTRL, 32'h4);
        check("ie_irq", {31'd0, timer_irq}, 32'h1);

        // COUNT write colliding with a match tick.
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'h0);
        wr(A_CMP, 32'h3);
        wr(A_CTRL, 32'h3);
        step_n(2);
        wr(A_CNT, 32'h100);
        rd(A_CNT, d);  check("col_cnt_val", d, 32'h101);
        rd(A_STAT, d); check("col_cnt_match", d, 32'h0);

        // W1C colliding with the second match: set wins.
        wr(A_CTRL, 32'h0);
        wr(A_CNT, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h3);
        step_n(6);
        wr(A_STAT, 32'h1);
        rd(A_STAT, d); check("col_w1c", d, 32'h1);

        // Reset mid-count.
        wr(A_CTRL, 32'h7);
        check("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
        rst = 1'b1;
        step_n(1);
        rst = 1'b0;
        check("mid_rst_irq", {31'd0, timer_irq}, 32'h0);
        rd(A_CNT, d);   check("mid_rst_cnt", d, 32'h0);
        rd(12'h020, d); check("addr_0x20", d, 32'h0);
        rd(12'h014, d); check("addr_0x14", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
